// File: rtl/booth_multiplier.sv
// Sequential 32x32 signed radix-2 Booth multiplier with a start/result-ready handshake.
// A carry-lookahead add/subtract engine performs the single add/subtract in each iteration.

module carry_lookahead_adder #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             subtraction,
   output logic [WIDTH-1:0] sum,
   output logic             overflow
);
   logic [WIDTH-1:0] b_eff;
   logic [WIDTH-1:0] g;
   logic [WIDTH-1:0] p;
   logic [WIDTH:0]   c;

   assign b_eff = b ^ {WIDTH{subtraction}};
   assign g     = a & b_eff;
   assign p     = a ^ b_eff;

   // 4-bit lookahead groups; each group's carry-out feeds the next group's carry-in.
   always_comb begin
      c    = '0;
      c[0] = subtraction;
      for (int k = 0; k < WIDTH / 4; k++) begin
         c[4*k+1] = g[4*k] | (p[4*k] & c[4*k]);
         c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & c[4*k]);
         c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
                  | (p[4*k+2] & p[4*k+1] & p[4*k] & c[4*k]);
         c[4*k+4] = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                  | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k])
                  | (p[4*k+3] & p[4*k+2] & p[4*k+1] & p[4*k] & c[4*k]);
      end
   end

   assign sum      = p ^ c[WIDTH-1:0];
   assign overflow = c[WIDTH] ^ c[WIDTH-1];
endmodule

module booth_multiplier #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             ctrl_MULT,
   input  logic [WIDTH-1:0] data_operandA,
   input  logic [WIDTH-1:0] data_operandB,
   output logic [WIDTH-1:0] data_result,
   output logic             data_exception,
   output logic             data_resultRDY,
   output logic             busy,
   output logic [1:0]       dbg_state
);
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [WIDTH-1:0]     m_q, m_d;
   logic [2*WIDTH:0]     p_q, p_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [WIDTH-1:0]     result_q, result_d;
   logic                 exc_q, exc_d;
   logic                 rdy_q, rdy_d;
   logic                 busy_q, busy_d;

   logic [WIDTH-1:0]     add_sum;
   logic                 add_ovf;
   logic                 add_active;
   logic                 add_sub;
   logic [WIDTH-1:0]     upper_new;
   logic                 sign_in;
   logic [2*WIDTH:0]     p_shift;

   assign add_sub    = (p_q[1:0] == 2'b10);
   assign add_active = p_q[1] ^ p_q[0];

   carry_lookahead_adder #(.WIDTH(WIDTH)) u_adder (
      .a           (p_q[2*WIDTH:WIDTH+1]),
      .b           (m_q),
      .subtraction (add_sub),
      .sum         (add_sum),
      .overflow    (add_ovf)
   );

   // The shifted-in MSB is the true sign of the add/sub result, so an overflowing
   // step (e.g. subtracting 0x80000000) still shifts in the correct sign.
   always_comb begin
      upper_new = add_active ? add_sum : p_q[2*WIDTH:WIDTH+1];
      sign_in   = add_active ? (add_sum[WIDTH-1] ^ add_ovf) : p_q[2*WIDTH];
      p_shift   = {sign_in, upper_new, p_q[WIDTH:1]};
   end

   always_comb begin
      state_d  = state_q;
      m_d      = m_q;
      p_d      = p_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      exc_d    = exc_q;
      rdy_d    = 1'b0;
      busy_d   = busy_q;
      if (ctrl_MULT) begin
         m_d     = data_operandA;
         p_d     = {{WIDTH{1'b0}}, data_operandB, 1'b0};
         cnt_d   = '0;
         state_d = S_RUN;
         busy_d  = 1'b1;
      end else begin
         case (state_q)
            S_RUN: begin
               p_d   = p_shift;
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == CNT_W'(WIDTH - 1)) begin
                  state_d  = S_DONE;
                  rdy_d    = 1'b1;
                  result_d = p_shift[WIDTH:1];
                  exc_d    = (p_shift[2*WIDTH:WIDTH+1] != {WIDTH{p_shift[WIDTH]}});
               end
            end
            S_DONE: begin
               state_d = S_IDLE;
               busy_d  = 1'b0;
            end
            default: begin
               state_d = S_IDLE;
               busy_d  = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q  <= S_IDLE;
         m_q      <= '0;
         p_q      <= '0;
         cnt_q    <= '0;
         result_q <= '0;
         exc_q    <= 1'b0;
         rdy_q    <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         m_q      <= m_d;
         p_q      <= p_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
         exc_q    <= exc_d;
         rdy_q    <= rdy_d;
         busy_q   <= busy_d;
      end
   end

   assign data_result    = result_q;
   assign data_exception = exc_q;
   assign data_resultRDY = rdy_q;
   assign busy           = busy_q;
   assign dbg_state      = state_q;
endmodule
